// File: rtl/add_1_pkg.sv
// Shared constants and helpers for the add_1 full adder with its carry-event counter.
package add_1_pkg;

  localparam int CNT_W_DEF = 8;

  // All-ones value of a w-bit counter (w in 1..32), used as the saturation ceiling.
  function automatic logic [31:0] cnt_sat_max(input int w);
    logic [32:0] pow2;
    pow2 = 33'd1 << w;
    return 32'(pow2 - 33'd1);
  endfunction

endpackage

// File: rtl/half_add.sv
// Single-bit half adder: sum and carry of two bits.
module half_add (
  input  logic a,
  input  logic b,
  output logic s,
  output logic c
);

  assign s = a ^ b;
  assign c = a & b;

endmodule

// File: rtl/add_1.sv
// One-bit full adder with combinational and registered outputs, plus a saturating
// counter of clock edges that see a carry-out.
module add_1
  import add_1_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_0,
  input  logic             in_1,
  input  logic             cin,
  output logic             out,
  output logic             cout,
  output logic             out_q,
  output logic             cout_q,
  output logic [CNT_W-1:0] carry_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(cnt_sat_max(CNT_W));

  logic             w_s0;
  logic             w_c0;
  logic             w_c1;
  logic             r_sum_p1;
  logic             r_cout_p1;
  logic [CNT_W-1:0] r_cnt_p1;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_W'(1);
  endfunction

  // Stage 0: combinational full adder from two cascaded half adders.
  half_add u_ha0 (
    .a (in_0),
    .b (in_1),
    .s (w_s0),
    .c (w_c0)
  );

  half_add u_ha1 (
    .a (w_s0),
    .b (cin),
    .s (out),
    .c (w_c1)
  );

  assign cout = w_c0 | w_c1;

  // Stage 1: registered sum/carry and the carry-event counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sum_p1  <= 1'b0;
      r_cout_p1 <= 1'b0;
      r_cnt_p1  <= '0;
    end else begin
      r_sum_p1  <= out;
      r_cout_p1 <= cout;
      if (cout) begin
        r_cnt_p1 <= sat_inc(r_cnt_p1);
      end
    end
  end

  assign out_q     = r_sum_p1;
  assign cout_q    = r_cout_p1;
  assign carry_cnt = r_cnt_p1;

endmodule

// File: tb/tb_add_1.sv
// Scoreboard bench for add_1: arithmetic reference model feeds expectation queues,
// independent monitors pop and compare.
module tb_add_1;

  localparam int CNT_W   = 2;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_0;
  logic             in_1;
  logic             cin;
  logic             out;
  logic             cout;
  logic             out_q;
  logic             cout_q;
  logic [CNT_W-1:0] carry_cnt;

  bit clk_en = 1'b0;
  int checks = 0;
  int errors = 0;

  typedef struct {
    string      name;
    logic [1:0] sum;
  } comb_exp_t;

  typedef struct {
    string name;
    logic  oq;
    logic  cq;
    int    cnt;
  } reg_exp_t;

  comb_exp_t comb_q[$];
  reg_exp_t  reg_q[$];
  event      ev_comb;
  event      ev_reg;

  int        m_cnt = 0;
  int        m_s;
  reg_exp_t  m_e;
  string     reg_tag = "clk";

  add_1 #(.CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_0      (in_0),
    .in_1      (in_1),
    .cin       (cin),
    .out       (out),
    .cout      (cout),
    .out_q     (out_q),
    .cout_q    (cout_q),
    .carry_cnt (carry_cnt)
  );

  always #5 if (clk_en) clk = ~clk;

  // Reference model: arithmetic sum sampled at each rising edge, counter clamps at max.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_cnt = 0;
    end else begin
      m_s = int'(in_0) + int'(in_1) + int'(cin);
      if (m_s >= 2 && m_cnt < CNT_MAX) m_cnt = m_cnt + 1;
      m_e.name = reg_tag;
      m_e.oq   = (m_s % 2) == 1;
      m_e.cq   = m_s >= 2;
      m_e.cnt  = m_cnt;
      reg_q.push_back(m_e);
    end
  end

  // Combinational monitor.
  always begin
    comb_exp_t ce;
    @(ev_comb);
    while (comb_q.size() > 0) begin
      ce = comb_q.pop_front();
      checks++;
      if ({cout, out} !== ce.sum) begin
        errors++;
        $display("FAIL %s: {cout,out} got %b want %b", ce.name, {cout, out}, ce.sum);
      end
    end
  end

  // Registered-output monitor.
  always begin
    reg_exp_t re;
    @(ev_reg or negedge clk);
    while (reg_q.size() > 0) begin
      re = reg_q.pop_front();
      checks++;
      if (out_q !== re.oq || cout_q !== re.cq || int'(carry_cnt) != re.cnt
          || $isunknown(carry_cnt)) begin
        errors++;
        $display("FAIL %s: out_q/cout_q/carry_cnt got %b/%b/%0d want %b/%b/%0d",
                 re.name, out_q, cout_q, carry_cnt, re.oq, re.cq, re.cnt);
      end
    end
  end

  task automatic comb_chk(input logic a, input logic b, input logic c, input string nm);
    comb_exp_t ce;
    in_0 = a;
    in_1 = b;
    cin  = c;
    ce.name = nm;
    ce.sum  = 2'(int'(a) + int'(b) + int'(c));
    comb_q.push_back(ce);
    #1 -> ev_comb;
    #1;
  endtask

  task automatic reg_now(input string nm, input logic oq, input logic cq, input int cnt);
    reg_exp_t re;
    re.name = nm;
    re.oq   = oq;
    re.cq   = cq;
    re.cnt  = cnt;
    reg_q.push_back(re);
    #1 -> ev_reg;
  endtask

  task automatic drive(input logic a, input logic b, input logic c, input string nm);
    @(negedge clk);
    in_0    = a;
    in_1    = b;
    cin     = c;
    reg_tag = nm;
  endtask

  // Reset in the low phase, check immediate clear and live combinational path.
  task automatic async_reset(input string nm);
    @(negedge clk);
    #1 rst_n = 1'b0;
    reg_now({nm, "_regs"}, 1'b0, 1'b0, 0);
    comb_chk(1'b1, 1'b0, 1'b1, {nm, "_comb"});
    in_0 = 1'b0;
    in_1 = 1'b0;
    cin  = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, got no finish want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0;
    in_0  = 1'b0;
    in_1  = 1'b0;
    cin   = 1'b0;
    #1;
    reg_now("reset_state", 1'b0, 1'b0, 0);
    #1;

    comb_chk(1'b1, 1'b0, 1'b0, "one_plus_zero_no_clk");
    for (int i = 0; i < 8; i++) begin
      logic [2:0] v;
      v = 3'(i);
      comb_chk(v[2], v[1], v[0], $sformatf("sweep_%03b", v));
    end

    rst_n = 1'b1;
    #1;
    for (int i = 0; i < 1000; i++) begin
      logic [2:0] v;
      v = 3'($urandom_range(0, 7));
      comb_chk(v[2], v[1], v[0], "rand_comb");
    end
    reg_now("regs_hold_no_clk", 1'b0, 1'b0, 0);
    #1;

    clk_en = 1'b1;
    drive(1'b1, 1'b1, 1'b0, "lat_110");
    drive(1'b0, 1'b0, 1'b0, "lat_000");
    async_reset("rst_a");

    for (int i = 0; i < 5; i++) drive(1'b1, 1'b1, 1'b1, $sformatf("sat_%0d", i));
    drive(1'b0, 1'b0, 1'b0, "sat_idle");
    async_reset("rst_b");

    drive(1'b1, 1'b1, 1'b0, "mid_1");
    drive(1'b0, 1'b1, 1'b1, "mid_2");
    drive(1'b0, 1'b0, 0, "mid_idle");
    async_reset("mid_count_reset");

    for (int i = 0; i < 200; i++) begin
      logic [2:0] v;
      @(negedge clk);
      v = 3'($urandom_range(0, 7));
      {in_0, in_1, cin} = v;
      #1;
      v = 3'($urandom_range(0, 7));
      {in_0, in_1, cin} = v;
      #1;
      v = 3'($urandom_range(0, 7));
      {in_0, in_1, cin} = v;
      reg_tag = "rand_clk";
    end
    drive(1'b0, 1'b0, 1'b0, "tail");
    @(negedge clk);
    @(negedge clk);
    #1;

    checks++;
    if (comb_q.size() != 0 || reg_q.size() != 0) begin
      errors++;
      $display("FAIL drain: pending comb/reg got %0d/%0d want 0/0", comb_q.size(), reg_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
